// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline package: datapath widths, control-bit positions and the
// ID/EX register record used by the stage registers and the forwarding unit.
package id_ex_stage_pkg;

    localparam int CTRL_W = 10;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    // Control word packing, MSB first:
    // {regwrite, memtoreg, memread, memwrite, branch, regdst, alusrc, aluop[2:0]}
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALUOP    = 0;
    localparam int CTRL_ALUOP_W  = 3;

    typedef logic [REG_W-1:0]  reg_num_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef struct packed {
        logic     valid;
        ctrl_t    ctrl;
        reg_num_t regs;
        reg_num_t regt;
        reg_num_t regd;
        word_t    rs_data;
        word_t    rt_data;
        word_t    imm;
        word_t    pc_plus4;
    } idex_t;

    // What the stage register does on the next rising edge.
    typedef enum logic [1:0] {
        CAPTURE_ID,
        BUBBLE_FLUSH,
        BUBBLE_HAZARD
    } idex_action_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and registered ID/EX outputs of the execute stage register.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    reg_num_t id_regs;
    reg_num_t id_regt;
    reg_num_t id_regd;
    word_t    id_rs_data;
    word_t    id_rt_data;
    word_t    id_imm;
    word_t    id_pc_plus4;
    ctrl_t    id_ctrl;

    reg_num_t idex_regs;
    reg_num_t idex_regt;
    reg_num_t idex_regd;
    word_t    idex_rs_data;
    word_t    idex_rt_data;
    word_t    idex_imm;
    word_t    idex_pc_plus4;
    ctrl_t    idex_ctrl;
    logic     idex_valid;

    modport master (
        output id_regs, id_regt, id_regd, id_rs_data, id_rt_data, id_imm,
               id_pc_plus4, id_ctrl,
        input  idex_regs, idex_regt, idex_regd, idex_rs_data, idex_rt_data,
               idex_imm, idex_pc_plus4, idex_ctrl, idex_valid
    );

    modport slave (
        input  id_regs, id_regt, id_regd, id_rs_data, id_rt_data, id_imm,
               id_pc_plus4, id_ctrl,
        output idex_regs, idex_regt, idex_regd, idex_rs_data, idex_rt_data,
               idex_imm, idex_pc_plus4, idex_ctrl, idex_valid
    );

endinterface

// File: rtl/id_ex_stage_hazard_detection.sv
// Load-use hazard compare: a load in EX whose target feeds either source of
// the instruction in ID. Register $0 is hard-wired and never creates a hazard.
module hazard_detection
    import id_ex_stage_pkg::*;
(
    input  logic     idex_valid,
    input  logic     idex_memread,
    input  reg_num_t idex_regt,
    input  reg_num_t id_regs,
    input  reg_num_t id_regt,
    output logic     hazard
);

    // Both sources are compared even when the ID instruction ignores rt;
    // the occasional needless stall is cheaper than decoding the format here.
    assign hazard = idex_valid & idex_memread & (idex_regt != '0) &
                    ((idex_regt == id_regs) | (idex_regt == id_regt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush squashing
// and saturating bubble/flush event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 cnt_clr_i,
    id_ex_stage_if.slave         stage,
    output logic                 stall_o,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    idex_t        idex_q;
    idex_t        idex_d;
    idex_action_t action;
    logic         hazard;

    hazard_detection u_hazard (
        .idex_valid   (idex_q.valid),
        .idex_memread (idex_q.ctrl[CTRL_MEMREAD]),
        .idex_regt    (idex_q.regt),
        .id_regs      (stage.id_regs),
        .id_regt      (stage.id_regt),
        .hazard       (hazard)
    );

    // A squash supersedes the stall: the dependent instruction is discarded anyway.
    assign stall_o = hazard & ~flush_i;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        action = CAPTURE_ID;
        idex_d = '0;
        if (flush_i) begin
            action = BUBBLE_FLUSH;
        end else if (hazard) begin
            action = BUBBLE_HAZARD;
        end

        if (action == CAPTURE_ID) begin
            idex_d.valid    = 1'b1;
            idex_d.ctrl     = stage.id_ctrl;
            idex_d.regs     = stage.id_regs;
            idex_d.regt     = stage.id_regt;
            idex_d.regd     = stage.id_regd;
            idex_d.rs_data  = stage.id_rs_data;
            idex_d.rt_data  = stage.id_rt_data;
            idex_d.imm      = stage.id_imm;
            idex_d.pc_plus4 = stage.id_pc_plus4;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // Counters hold at all-ones; clear wins over a same-edge increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (cnt_clr_i) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (action == BUBBLE_HAZARD && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
            end
            if (flush_i && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign stage.idex_valid    = idex_q.valid;
    assign stage.idex_ctrl     = idex_q.ctrl;
    assign stage.idex_regs     = idex_q.regs;
    assign stage.idex_regt     = idex_q.regt;
    assign stage.idex_regd     = idex_q.regd;
    assign stage.idex_rs_data  = idex_q.rs_data;
    assign stage.idex_rt_data  = idex_q.rt_data;
    assign stage.idex_imm      = idex_q.imm;
    assign stage.idex_pc_plus4 = idex_q.pc_plus4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/reset scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        cnt_clr_i = 1'b0;
    logic        stall_o;
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;
    logic        sat_stall;
    logic [3:0]  sat_bubble_cnt;
    logic [3:0]  sat_flush_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [9:0] LW_CTRL = 10'h388;
    localparam logic [9:0] R_CTRL  = 10'h212;

    always #5 clk_i = ~clk_i;

    id_ex_stage_if bus ();
    id_ex_stage_if sat_bus ();

    id_ex_stage dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .cnt_clr_i  (cnt_clr_i),
        .stage      (bus.slave),
        .stall_o    (stall_o),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    // Narrow-counter copy fed the same inputs so saturation is reachable quickly.
    id_ex_stage #(.CNT_WIDTH(4)) dut_sat (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .cnt_clr_i  (cnt_clr_i),
        .stage      (sat_bus.slave),
        .stall_o    (sat_stall),
        .bubble_cnt (sat_bubble_cnt),
        .flush_cnt  (sat_flush_cnt)
    );

    assign sat_bus.id_regs     = bus.id_regs;
    assign sat_bus.id_regt     = bus.id_regt;
    assign sat_bus.id_regd     = bus.id_regd;
    assign sat_bus.id_rs_data  = bus.id_rs_data;
    assign sat_bus.id_rt_data  = bus.id_rt_data;
    assign sat_bus.id_imm      = bus.id_imm;
    assign sat_bus.id_pc_plus4 = bus.id_pc_plus4;
    assign sat_bus.id_ctrl     = bus.id_ctrl;

    // Behavioural model of the stage contents and event counts.
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [4:0]  m_regs, m_regt, m_regd;
    logic [31:0] m_rs, m_rt, m_imm, m_pc;
    int          m_bub, m_fl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit model_hazard();
        return m_valid && m_ctrl[7] && (m_regt != 0) &&
               ((m_regt == bus.id_regs) || (m_regt == bus.id_regt));
    endfunction

    task automatic model_empty();
        m_valid = 0; m_ctrl = 0; m_regs = 0; m_regt = 0; m_regd = 0;
        m_rs = 0; m_rt = 0; m_imm = 0; m_pc = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":valid"}, bus.idex_valid, m_valid);
        check({tag, ":ctrl"}, bus.idex_ctrl, m_ctrl);
        check({tag, ":regs"}, bus.idex_regs, m_regs);
        check({tag, ":regt"}, bus.idex_regt, m_regt);
        check({tag, ":regd"}, bus.idex_regd, m_regd);
        check({tag, ":rs_data"}, bus.idex_rs_data, m_rs);
        check({tag, ":rt_data"}, bus.idex_rt_data, m_rt);
        check({tag, ":imm"}, bus.idex_imm, m_imm);
        check({tag, ":pc_plus4"}, bus.idex_pc_plus4, m_pc);
        check({tag, ":bubble_cnt"}, bubble_cnt, min_int(m_bub, 65535));
        check({tag, ":flush_cnt"}, flush_cnt, min_int(m_fl, 65535));
        check({tag, ":sat_bubble_cnt"}, sat_bubble_cnt, min_int(m_bub, 15));
        check({tag, ":sat_flush_cnt"}, sat_flush_cnt, min_int(m_fl, 15));
    endtask

    task automatic drive(input logic [4:0] rs_n, input logic [4:0] rt_n, input logic [4:0] rd_n,
                         input logic [9:0] ctrl, input logic [31:0] imm,
                         input logic fl, input logic clr);
        bus.id_regs     = rs_n;
        bus.id_regt     = rt_n;
        bus.id_regd     = rd_n;
        bus.id_ctrl     = ctrl;
        bus.id_imm      = imm;
        bus.id_rs_data  = $urandom;
        bus.id_rt_data  = $urandom;
        bus.id_pc_plus4 = $urandom;
        flush_i         = fl;
        cnt_clr_i       = clr;
    endtask

    // Starts and ends on a falling edge with inputs already applied.
    task automatic cycle(input string tag);
        bit hz;
        hz = model_hazard();
        #1;
        check({tag, ":stall"}, stall_o, hz && !flush_i);
        @(posedge clk_i);
        if (flush_i) begin
            model_empty();
            m_fl++;
        end else if (hz) begin
            model_empty();
            m_bub++;
        end else begin
            m_valid = 1;
            m_ctrl = bus.id_ctrl; m_regs = bus.id_regs; m_regt = bus.id_regt;
            m_regd = bus.id_regd; m_rs = bus.id_rs_data; m_rt = bus.id_rt_data;
            m_imm = bus.id_imm; m_pc = bus.id_pc_plus4;
        end
        if (cnt_clr_i) begin
            m_bub = 0;
            m_fl = 0;
        end
        #1;
        check_outputs(tag);
        @(negedge clk_i);
    endtask

    initial begin
        model_empty();
        m_bub = 0;
        m_fl = 0;

        // Reset state, with inputs that would hazard against a full stage.
        drive(5'd5, 5'd5, 5'd1, LW_CTRL, 32'h1234, 1'b0, 1'b0);
        #3;
        check("reset:stall", stall_o, 1'b0);
        check_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Passthrough.
        drive(5'd3, 5'd4, 5'd7, 10'h2A5, 32'hFFFF_FFF0, 1'b0, 1'b0);
        cycle("pass");
        check("pass:ctrl_const", bus.idex_ctrl, 10'h2A5);
        check("pass:imm_const", bus.idex_imm, 32'hFFFF_FFF0);
        check("pass:regs_const", {bus.idex_regs, bus.idex_regt, bus.idex_regd}, {5'd3, 5'd4, 5'd7});
        check("pass:valid_const", bus.idex_valid, 1'b1);

        // Load-use: one-cycle stall, then the dependent instruction enters.
        drive(5'd1, 5'd5, 5'd0, LW_CTRL, 32'h10, 1'b0, 1'b0);
        cycle("lu_load");
        drive(5'd5, 5'd2, 5'd6, R_CTRL, 32'h0, 1'b0, 1'b0);
        #1;
        check("lu:stall_hi", stall_o, 1'b1);
        cycle("lu_bubble");
        check("lu:valid_lo", bus.idex_valid, 1'b0);
        check("lu:bubble_one", bubble_cnt, 16'd1);
        #1;
        check("lu:stall_lo", stall_o, 1'b0);
        cycle("lu_dep");
        check("lu:dep_valid", bus.idex_valid, 1'b1);
        check("lu:dep_regs", bus.idex_regs, 5'd5);

        // Load into $0 never stalls.
        drive(5'd1, 5'd0, 5'd0, LW_CTRL, 32'h20, 1'b0, 1'b0);
        cycle("zero_load");
        drive(5'd0, 5'd0, 5'd3, R_CTRL, 32'h0, 1'b0, 1'b0);
        #1;
        check("zero:stall", stall_o, 1'b0);
        cycle("zero_dep");
        check("zero:valid", bus.idex_valid, 1'b1);
        check("zero:bubble_cnt", bubble_cnt, 16'd1);

        // Flush beats a simultaneous hazard.
        drive(5'd1, 5'd5, 5'd0, LW_CTRL, 32'h30, 1'b0, 1'b0);
        cycle("fl_load");
        drive(5'd5, 5'd9, 5'd2, R_CTRL, 32'h0, 1'b1, 1'b0);
        #1;
        check("fl:stall", stall_o, 1'b0);
        cycle("fl_squash");
        check("fl:valid", bus.idex_valid, 1'b0);
        check("fl:flush_cnt", flush_cnt, 16'd1);
        check("fl:bubble_cnt", bubble_cnt, 16'd1);
        flush_i = 1'b0;

        // Asynchronous reset while stalling with a full stage.
        drive(5'd1, 5'd5, 5'd0, LW_CTRL, 32'h40, 1'b0, 1'b0);
        cycle("rst_load");
        drive(5'd5, 5'd5, 5'd8, R_CTRL, 32'h0, 1'b0, 1'b0);
        #1;
        check("rst:stall_before", stall_o, 1'b1);
        rst_i = 1'b1;
        #1;
        model_empty();
        m_bub = 0;
        m_fl = 0;
        check("rst:stall_async", stall_o, 1'b0);
        check_outputs("rst_async");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        cycle("rst_capture");
        check("rst:capture_valid", bus.idex_valid, 1'b1);

        // Saturation: 20 hazard bubbles overflow the 4-bit copy.
        for (int i = 0; i < 20; i++) begin
            drive(5'd1, 5'd5, 5'd0, LW_CTRL, 32'h50, 1'b0, 1'b0);
            cycle("sat_load");
            drive(5'd2, 5'd5, 5'd4, R_CTRL, 32'h0, 1'b0, 1'b0);
            cycle("sat_bubble");
        end
        check("sat:narrow_held", sat_bubble_cnt, 4'hF);
        check("sat:wide_count", bubble_cnt, 16'd20);
        drive(5'd1, 5'd5, 5'd0, LW_CTRL, 32'h60, 1'b0, 1'b0);
        cycle("clr_load");
        drive(5'd5, 5'd1, 5'd4, R_CTRL, 32'h0, 1'b0, 1'b1);
        cycle("clr_hazard");
        check("clr:narrow_zero", sat_bubble_cnt, 4'h0);
        check("clr:wide_zero", bubble_cnt, 16'h0);
        check("clr:bubble_still", bus.idex_valid, 1'b0);
        cnt_clr_i = 1'b0;

        // Randomized traffic with a small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [9:0] c;
            c = 10'($urandom);
            c[7] = ($urandom_range(0, 2) != 0);
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  c, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 31) == 0));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
